// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU result stage and its users.
//   - FLAG_* : bit positions of the ALU status flags inside a 4-bit flag word.
//   - SEL_*  : ALU opcodes, as carried on sel and stored as the result tag.
//   - alu_entry_t : one stored result for the default 32-bit ALU.
//   - pack_flags() : assembles the flag word from the individual ALU flags.
package alu_pkg;

   localparam int unsigned FLAG_COUT = 3;
   localparam int unsigned FLAG_NEG  = 2;
   localparam int unsigned FLAG_ZERO = 1;
   localparam int unsigned FLAG_OVF  = 0;

   localparam logic [3:0] SEL_AND = 4'b0000;
   localparam logic [3:0] SEL_OR  = 4'b0001;
   localparam logic [3:0] SEL_ADD = 4'b0110;
   localparam logic [3:0] SEL_SUB = 4'b0111;

   localparam int unsigned ALU_WIDTH = 32;

   typedef logic [3:0] alu_flags_t;
   typedef logic [3:0] alu_sel_t;

   typedef struct packed {
      logic [ALU_WIDTH-1:0] result;
      alu_flags_t           flags;
      alu_sel_t             sel;
   } alu_entry_t;

   function automatic alu_flags_t pack_flags(input logic cout, input logic neg,
                                             input logic zero, input logic ovf);
      alu_flags_t f;
      f            = '0;
      f[FLAG_COUT] = cout;
      f[FLAG_NEG]  = neg;
      f[FLAG_ZERO] = zero;
      f[FLAG_OVF]  = ovf;
      return f;
   endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// alu_result_stage_if: ALU-to-stage capture bus and stage-to-consumer result bus.
//   Capture : in_valid, in_ready, Y, Cout, Negative, Zero, Overflow, sel
//   Result  : out_valid, out_ready, out_Y, out_flags ({Cout,Negative,Zero,Overflow}), out_sel
//   master  : the ALU/consumer side; slave : the result stage.
interface alu_result_stage_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] Y;
   logic             Cout;
   logic             Negative;
   logic             Zero;
   logic             Overflow;
   logic [3:0]       sel;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_Y;
   logic [3:0]       out_flags;
   logic [3:0]       out_sel;

   modport master (
      output in_valid, Y, Cout, Negative, Zero, Overflow, sel, out_ready,
      input  in_ready, out_valid, out_Y, out_flags, out_sel
   );

   modport slave (
      input  in_valid, Y, Cout, Negative, Zero, Overflow, sel, out_ready,
      output in_ready, out_valid, out_Y, out_flags, out_sel
   );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count.
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   push_i    : write wdata_i at the tail (ignored when full)
//   pop_i     : drop the head entry (ignored when empty)
//   rdata_o   : head entry (undefined when empty)
//   full_o, empty_o, count_o : occupancy status
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wptr_q, wptr_d;
   logic [PtrW-1:0]  rptr_q, rptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CntW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rptr_q];

   always_comb begin
      do_push = push_i && !full_o;
      do_pop  = pop_i && !empty_o;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      // Pointers are exactly PtrW bits, so DEPTH-1 wraps to 0 for free.
      if (do_push) wptr_d = wptr_q + PtrW'(1);
      if (do_pop)  rptr_d = rptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_d = count_q + CntW'(1);
      else if (do_pop && !do_push) count_d = count_q - CntW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: it is only observed through a non-empty head.
   always_ff @(posedge clk) begin
      if (!rst && do_push) mem_q[wptr_q] <= wdata_i;
   end

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered result FIFO behind the combinational ALU.
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : capture handshake from the ALU and result handshake to the consumer
//   sticky_clr   : clear sticky_flags and ovf_count (a same-cycle push still counts)
//   sticky_flags : OR of flags of all accepted entries since last clear
//   ovf_count    : saturating count of accepted entries with Overflow set
//   count        : FIFO occupancy
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   alu_result_stage_if.slave      bus,
   input  logic                   sticky_clr,
   output logic [3:0]             sticky_flags,
   output logic [15:0]            ovf_count,
   output logic [$clog2(DEPTH):0] count
);
   typedef struct packed {
      logic [WIDTH-1:0] result;
      alu_flags_t       flags;
      alu_sel_t         sel;
   } entry_t;

   entry_t     wr_entry, rd_entry;
   alu_flags_t in_flags;
   logic       full, empty, push, pop;
   alu_flags_t sticky_q, sticky_d;
   logic [15:0] ovf_q, ovf_d;

   sync_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .wdata_i (wr_entry),
      .pop_i   (pop),
      .rdata_o (rd_entry),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

   always_comb begin
      in_flags        = pack_flags(bus.Cout, bus.Negative, bus.Zero, bus.Overflow);
      wr_entry.result = bus.Y;
      wr_entry.flags  = in_flags;
      wr_entry.sel    = bus.sel;
      // No pass-through when full: readiness ignores out_ready.
      bus.in_ready    = !rst && !full;
      push            = bus.in_valid && bus.in_ready;
      bus.out_valid   = !empty;
      pop             = bus.out_valid && bus.out_ready;
      bus.out_Y       = empty ? '0 : rd_entry.result;
      bus.out_flags   = empty ? '0 : rd_entry.flags;
      bus.out_sel     = empty ? '0 : rd_entry.sel;
   end

   // Clear first, then merge the same-cycle push so no event is lost.
   always_comb begin
      sticky_d = sticky_clr ? '0 : sticky_q;
      ovf_d    = sticky_clr ? '0 : ovf_q;
      if (push) begin
         sticky_d = sticky_d | in_flags;
         if (in_flags[FLAG_OVF] && (ovf_d != 16'hFFFF)) ovf_d = ovf_d + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sticky_q <= '0;
         ovf_q    <= '0;
      end else begin
         sticky_q <= sticky_d;
         ovf_q    <= ovf_d;
      end
   end

   assign sticky_flags = sticky_q;
   assign ovf_count    = ovf_q;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;
   import alu_pkg::*;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned DEPTH = 4;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   sticky_clr = 1'b0;
   logic [3:0]             sticky_flags;
   logic [15:0]            ovf_count;
   logic [$clog2(DEPTH):0] count;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Reference model state
   alu_entry_t  q[$];
   logic [3:0]  m_sticky = '0;
   int          m_ovf = 0;
   bit          m_push, m_pop;
   logic [3:0]  m_fl;

   alu_result_stage_if #(.WIDTH(WIDTH)) bus ();

   alu_result_stage #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .sticky_clr   (sticky_clr),
      .sticky_flags (sticky_flags),
      .ovf_count    (ovf_count),
      .count        (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: FIFO as a queue, sticky/ovf from the plain rules.
   initial forever begin
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_sticky = '0;
         m_ovf    = 0;
      end else begin
         m_fl   = {bus.Cout, bus.Negative, bus.Zero, bus.Overflow};
         m_push = bus.in_valid && (q.size() < DEPTH);
         m_pop  = bus.out_ready && (q.size() > 0);
         if (m_pop) void'(q.pop_front());
         if (m_push) q.push_back('{result: bus.Y, flags: m_fl, sel: bus.sel});
         if (sticky_clr) begin
            m_sticky = '0;
            m_ovf    = 0;
         end
         if (m_push) begin
            m_sticky = m_sticky | m_fl;
            if (m_fl[0] && m_ovf < 65535) m_ovf++;
         end
      end
   end

   // Compare every cycle on the falling edge.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("in_ready", 32'(bus.in_ready), 32'(!rst && (q.size() != DEPTH)));
         chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
         chk("out_Y", bus.out_Y, (q.size() != 0) ? q[0].result : 32'h0);
         chk("out_flags", 32'(bus.out_flags), (q.size() != 0) ? 32'(q[0].flags) : 32'h0);
         chk("out_sel", 32'(bus.out_sel), (q.size() != 0) ? 32'(q[0].sel) : 32'h0);
         chk("count", 32'(count), 32'(q.size()));
         chk("sticky_flags", 32'(sticky_flags), 32'(m_sticky));
         chk("ovf_count", 32'(ovf_count), 32'(m_ovf));
      end
   end

   // One clock: apply inputs, then return just after the next falling edge.
   task automatic step(input bit iv, input logic [31:0] y, input logic [3:0] f,
                       input logic [3:0] s, input bit ordy, input bit clr);
      bus.in_valid  = iv;
      bus.Y         = y;
      {bus.Cout, bus.Negative, bus.Zero, bus.Overflow} = f;
      bus.sel       = s;
      bus.out_ready = ordy;
      sticky_clr    = clr;
      @(negedge clk);
      #1;
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.Y         = '0;
      bus.Cout      = 1'b0;
      bus.Negative  = 1'b0;
      bus.Zero      = 1'b0;
      bus.Overflow  = 1'b0;
      bus.sel       = '0;
      bus.out_ready = 1'b0;
      rst           = 1'b1;
      step(0, 0, 0, 0, 0, 0);
      chk_en = 1'b1;
      chk("in_ready_in_rst", 32'(bus.in_ready), 32'h0);
      step(0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      step(0, 0, 0, 0, 0, 0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_out_Y", bus.out_Y, 32'h0);
      chk("rst_sticky", 32'(sticky_flags), 32'h0);
      chk("rst_ovf", 32'(ovf_count), 32'h0);
      chk("rst_count", 32'(count), 32'h0);

      // Single push then pop
      step(1, 32'h5, 4'b0000, SEL_ADD, 0, 0);
      chk("one_valid", 32'(bus.out_valid), 32'h1);
      chk("one_Y", bus.out_Y, 32'h5);
      chk("one_sel", 32'(bus.out_sel), 32'h6);
      chk("one_count", 32'(count), 32'h1);
      step(0, 0, 0, 0, 1, 0);
      chk("pop_valid", 32'(bus.out_valid), 32'h0);
      chk("pop_Y", bus.out_Y, 32'h0);

      // Fill to full
      for (int i = 0; i < 4; i++) step(1, 32'h100 + i, 4'(i), 4'(i), 0, 0);
      chk("full_count", 32'(count), 32'h4);
      chk("full_in_ready", 32'(bus.in_ready), 32'h0);
      chk("full_head", bus.out_Y, 32'h100);
      step(1, 32'hDEAD, 4'b1111, SEL_SUB, 0, 0);
      chk("full_reject", 32'(count), 32'h4);
      step(1, 32'hBEEF, 4'b1111, SEL_SUB, 1, 0);
      chk("full_poppush", 32'(count), 32'h3);
      chk("drain0", bus.out_Y, 32'h101);
      step(0, 0, 0, 0, 1, 0);
      chk("drain1", bus.out_Y, 32'h102);
      chk("drain1_flags", 32'(bus.out_flags), 32'h2);
      step(0, 0, 0, 0, 1, 0);
      chk("drain2", bus.out_Y, 32'h103);
      step(0, 0, 0, 0, 1, 0);
      chk("drained", 32'(bus.out_valid), 32'h0);

      // Wrap-around at full rate
      for (int i = 0; i < 10; i++) begin
         step(1, 32'hA000 + i, 4'(i), (i % 2 == 0) ? SEL_AND : SEL_OR, 1, 0);
         chk("wrap_Y", bus.out_Y, 32'hA000 + i);
         chk("wrap_count", 32'(count), 32'h1);
      end
      step(0, 0, 0, 0, 1, 0);

      // Sticky flags and clear
      step(0, 0, 0, 0, 1, 1);
      step(1, 32'h1, 4'b0001, SEL_ADD, 1, 0);
      step(1, 32'h2, 4'b1000, SEL_SUB, 1, 0);
      chk("sticky_or", 32'(sticky_flags), 32'h9);
      chk("sticky_ovf", 32'(ovf_count), 32'h1);
      step(1, 32'h3, 4'b0101, SEL_ADD, 1, 1);
      chk("clr_push_sticky", 32'(sticky_flags), 32'h5);
      chk("clr_push_ovf", 32'(ovf_count), 32'h1);

      // Saturation
      for (int i = 0; i < 65537; i++) step(1, 32'(i), 4'b0001, SEL_ADD, 1, 0);
      chk("ovf_sat", 32'(ovf_count), 32'hFFFF);
      step(1, 32'h7, 4'b0001, SEL_ADD, 1, 0);
      chk("ovf_sat_hold", 32'(ovf_count), 32'hFFFF);
      step(0, 0, 0, 0, 1, 0);

      // Mid-operation reset
      for (int i = 0; i < 3; i++) step(1, 32'hC0 + i, 4'b0000, SEL_OR, 0, 0);
      chk("pre_rst_count", 32'(count), 32'h3);
      rst = 1'b1;
      step(0, 0, 0, 0, 0, 0);
      chk("mid_rst_count", 32'(count), 32'h0);
      chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
      chk("mid_rst_ovf", 32'(ovf_count), 32'h0);
      rst = 1'b0;
      step(0, 0, 0, 0, 0, 0);
      chk("post_rst_ready", 32'(bus.in_ready), 32'h1);
      step(1, 32'h1234, 4'b0110, SEL_SUB, 0, 0);
      chk("post_rst_Y", bus.out_Y, 32'h1234);
      chk("post_rst_flags", 32'(bus.out_flags), 32'h6);
      step(0, 0, 0, 0, 1, 0);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered result stage directly downstream of the combinational ALU. Each cycle it captures the ALU result word, its four status flags and the opcode that produced them into a small FIFO. It presents them to the consumer with a valid/ready handshake. It also keeps sticky status flags and a saturating overflow-event counter for software inspection.

## Interface
Parameters:
- WIDTH, 32: data width, matches ALU Y.
- DEPTH, 4: FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ALU outputs below are a result to capture.
- in_ready  out  1  stage can accept this cycle.
- Y  in  WIDTH  ALU result.
- Cout, Negative, Zero, Overflow  in  1 each  ALU status flags.
- sel  in  4  ALU opcode for this result, stored as tag.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer takes head entry.
- out_Y  out  WIDTH  head result.
- out_flags  out  4  head flags {Cout, Negative, Zero, Overflow}, bit 3 = Cout.
- out_sel  out  4  head opcode tag.
- sticky_flags  out  4  OR of the flags of every accepted entry since the last clear; same bit order as out_flags.
- sticky_clr  in  1  clear sticky_flags and ovf_count.
- ovf_count  out  16  number of accepted entries with Overflow=1, saturating.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Push: in_valid && in_ready. The entry {Y, Cout, Negative, Zero, Overflow, sel} is written at the tail and the write pointer increments.
- Pop: out_valid && out_ready. The read pointer increments.
- in_ready = !rst && (count != DEPTH). There is no pass-through when full, even if a pop occurs in the same cycle.
- out_valid = (count != 0).
- When empty, out_Y, out_flags and out_sel are driven to 0. When not empty, they show the head entry.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Occupancy:
  - push and pop in the same cycle: count unchanged.
  - push only: count+1.
  - pop only: count-1.
- Sticky flags, on a push with flags f:
  - sticky_flags <= (sticky_clr ? 0 : sticky_flags) | f.
  - With no push, sticky_clr sets sticky_flags to 0.
  - An event accepted in the clear cycle is therefore never lost.
- Overflow counter:
  - On a push with Overflow=1: ovf_count <= (sticky_clr ? 0 : ovf_count) + 1, saturating at 16'hFFFF.
  - With no such push, sticky_clr sets ovf_count to 0.
  - Saturation holds until cleared or reset.
- Input fields are don't-care while in_valid=0. Flags are stored exactly as presented; the stage does not recompute or check them.

## Timing
- Reset (rst=1 at a rising edge): pointers and count go to 0, so out_valid=0 and out_* =0. sticky_flags=0, ovf_count=0.
- in_ready is 0 while rst is high and 1 in the first cycle after rst is released.
- Reset mid-operation discards all stored entries. No pop is signalled for the discarded entries.
- Latency: an entry pushed at edge N appears on out_* with out_valid=1 after edge N. There is no combinational input-to-output bypass.
- in_ready depends only on rst and count; it never depends on out_ready.
- out_* are held stable while out_valid=1 and out_ready=0.
- Throughput is one entry per cycle sustained when out_ready=1.
- sticky_flags, ovf_count and count reflect pushes and pops of edge N immediately after edge N.

## Structure
- Shared package alu_pkg holds:
  - flag bit index constants: FLAG_COUT=3, FLAG_NEG=2, FLAG_ZERO=1, FLAG_OVF=0.
  - the 4-bit opcode constants used by the ALU sel (e.g. SEL_ADD=4'b0110, SEL_SUB=4'b0111).
  - the packed entry typedef {result, flags, sel}.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH), holds storage, pointers and count. alu_result_stage adds the sticky/counter logic and the output zeroing.

## Test plan
- Reset then idle: after rst, in_ready=1, out_valid=0, out_Y=0, sticky_flags=0, ovf_count=0, count=0.
- Push Y=32'h0000_0005, flags 4'b0000, sel=4'b0110 with out_ready=0. The next cycle shows out_valid=1, out_Y=5, out_sel=4'b0110, count=1. Raising out_ready pops it; out_valid=0 and out_Y=0 the following cycle.
- Fill to full:
  - Push 4 entries (DEPTH=4) with out_ready=0: count=4, in_ready=0.
  - A 5th in_valid is not accepted.
  - Pop and push in the same cycle while full: only the pop occurs, count=3.
  - Draining returns the entries in push order.
- Wrap-around: run 10 push/pop pairs at full rate with out_ready=1. Every entry emerges one cycle after its push, with no loss, and count stays at 1.
- Sticky and clear:
  - Push one entry with flags 4'b0001 and one with 4'b1000: sticky_flags=4'b1001, ovf_count=1.
  - Assert sticky_clr in the same cycle as a push with flags 4'b0101: sticky_flags=4'b0101, ovf_count=1.
- Saturation and mid-operation reset:
  - Preload ovf_count near 16'hFFFF via 65537 overflow pushes: ovf_count=16'hFFFF.
  - Assert rst with 3 entries queued: count=0, out_valid=0, ovf_count=0 the next cycle.
